// File: rtl/score_keeper.sv
// score_keeper: receives single-cycle collision pulses, queues them in a
// six-bit pending register and adds each object's point value to a four-digit
// BCD score. The addition is serial, one digit per clock. A frame-timed combo
// multiplier sets how many times the value is added (x1/x2/x4). The block also
// drives the score display value and the extra-ball pulse.
//
// Build option: define SCORE_COMBO_EN to build the combo timer and multiplier.
// Without it, combo_level is tied to 0 and every hit is added once.
module score_keeper #(
  parameter logic [7:0] PTS_STAR     = 8'h10,
  parameter logic [7:0] PTS_PLUS     = 8'h20,
  parameter logic [7:0] PTS_MUSHROOM = 8'h50,
  parameter logic [7:0] PTS_COIL     = 8'h05,
  parameter logic [7:0] PTS_PLANT    = 8'h25,
  parameter logic [7:0] PTS_TRIANGLE = 8'h01,
  parameter logic [7:0] COMBO_FRAMES = 8'd30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        hit_star_pulse,
  input  logic        hit_plus_pulse,
  input  logic        hit_mushroom_pulse,
  input  logic        hit_coil_pulse,
  input  logic        hit_plant_pulse,
  input  logic        hit_triangle_pulse,
  input  logic        clear_score,
  output logic [15:0] score_bcd,
  output logic        score_busy,
  output logic [1:0]  combo_level,
  output logic        score_overflow,
  output logic        extra_ball_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_D0     = 3'd2,
    ST_D1     = 3'd3,
    ST_D2     = 3'd4,
    ST_D3     = 3'd5,
    ST_COMMIT = 3'd6
  } state_t;

  state_t      state_r;
  logic [5:0]  pending_r;
  logic [15:0] work_r;
  logic [7:0]  addend_r;
  logic [2:0]  sel_r;
  logic [2:0]  passes_r;
  logic        carry_r;

  logic [5:0]  hit_s;
  logic [5:0]  clr_mask_s;
  logic [2:0]  pick_s;
  logic [2:0]  passes_init_s;
  logic [3:0]  work_dig_s;
  logic [3:0]  add_dig_s;
  logic [4:0]  dig_sum_s;

  // Lowest set index wins (star has the highest priority)
  function automatic logic [2:0] first_index(input logic [5:0] p);
    logic [2:0] idx;
    casez (p)
      6'b?????1: idx = 3'd0;
      6'b????10: idx = 3'd1;
      6'b???100: idx = 3'd2;
      6'b??1000: idx = 3'd3;
      6'b?10000: idx = 3'd4;
      6'b100000: idx = 3'd5;
      default:   idx = 3'd0;
    endcase
    return idx;
  endfunction

  // BCD point value of each object
  function automatic logic [7:0] pts_of(input logic [2:0] idx);
    logic [7:0] pts;
    case (idx)
      3'd0:    pts = PTS_STAR;
      3'd1:    pts = PTS_PLUS;
      3'd2:    pts = PTS_MUSHROOM;
      3'd3:    pts = PTS_COIL;
      3'd4:    pts = PTS_PLANT;
      3'd5:    pts = PTS_TRIANGLE;
      default: pts = 8'h00;
    endcase
    return pts;
  endfunction

  // One BCD digit add: returns {carry_out, digit}
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] s;
    logic [4:0] t;
    logic [4:0] r;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    t = s - 5'd10;
    if (s > 5'd9) begin
      r = {1'b1, t[3:0]};
    end else begin
      r = {1'b0, s[3:0]};
    end
    return r;
  endfunction

  assign hit_s  = {hit_triangle_pulse, hit_plant_pulse, hit_coil_pulse,
                   hit_mushroom_pulse, hit_plus_pulse, hit_star_pulse};
  assign pick_s = first_index(pending_r);

  // Select the work/addend digit that the current digit state operates on
  always_comb begin
    work_dig_s = 4'd0;
    add_dig_s  = 4'd0;
    case (state_r)
      ST_D0: begin
        work_dig_s = work_r[3:0];
        add_dig_s  = addend_r[3:0];
      end
      ST_D1: begin
        work_dig_s = work_r[7:4];
        add_dig_s  = addend_r[7:4];
      end
      ST_D2: begin
        work_dig_s = work_r[11:8];
        add_dig_s  = 4'd0;
      end
      ST_D3: begin
        work_dig_s = work_r[15:12];
        add_dig_s  = 4'd0;
      end
      default: begin
        work_dig_s = 4'd0;
        add_dig_s  = 4'd0;
      end
    endcase
    dig_sum_s = bcd_digit_add(work_dig_s, add_dig_s, carry_r);
  end

  // Pending bit retired by the event being committed this cycle
  always_comb begin
    clr_mask_s = 6'd0;
    if (state_r == ST_COMMIT) begin
      clr_mask_s = 6'd1 << sel_r;
    end else begin
      clr_mask_s = 6'd0;
    end
  end

  // Pending hits: a new pulse wins over the commit clear of the same bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 6'd0;
    end else if (clear_score) begin
      pending_r <= 6'd0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | hit_s;
    end
  end

`ifdef SCORE_COMBO_EN
  logic [7:0] frame_cnt_r;

  assign passes_init_s = 3'd1 << combo_level;

  // Combo timer: commits raise the level, COMBO_FRAMES idle frames drop it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= 8'd0;
      combo_level <= 2'd0;
    end else if (clear_score) begin
      frame_cnt_r <= 8'd0;
      combo_level <= 2'd0;
    end else if (state_r == ST_COMMIT) begin
      frame_cnt_r <= 8'd0;
      if (combo_level != 2'd2) begin
        combo_level <= combo_level + 2'd1;
      end
    end else begin
      if (startOfFrame && (frame_cnt_r != 8'd255)) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      if (frame_cnt_r >= COMBO_FRAMES) begin
        combo_level <= 2'd0;
      end
    end
  end
`else
  logic unused_cfg_s;

  assign passes_init_s = 3'd1;
  assign combo_level   = 2'd0;
  assign unused_cfg_s  = startOfFrame ^ (COMBO_FRAMES == 8'd0);
`endif

  // Serial BCD adder FSM with registered score/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      work_r           <= 16'h0000;
      addend_r         <= 8'h00;
      sel_r            <= 3'd0;
      passes_r         <= 3'd0;
      carry_r          <= 1'b0;
      score_bcd        <= 16'h0000;
      score_busy       <= 1'b0;
      score_overflow   <= 1'b0;
      extra_ball_pulse <= 1'b0;
    end else if (clear_score) begin
      state_r          <= ST_IDLE;
      work_r           <= 16'h0000;
      carry_r          <= 1'b0;
      passes_r         <= 3'd0;
      score_bcd        <= 16'h0000;
      score_busy       <= 1'b0;
      score_overflow   <= 1'b0;
      extra_ball_pulse <= 1'b0;
    end else begin
      extra_ball_pulse <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pending_r != 6'd0) begin
            state_r    <= ST_LOAD;
            score_busy <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            score_busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          sel_r    <= pick_s;
          addend_r <= pts_of(pick_s);
          work_r   <= score_bcd;
          passes_r <= passes_init_s;
          carry_r  <= 1'b0;
          state_r  <= ST_D0;
        end
        ST_D0: begin
          work_r[3:0] <= dig_sum_s[3:0];
          carry_r     <= dig_sum_s[4];
          state_r     <= ST_D1;
        end
        ST_D1: begin
          work_r[7:4] <= dig_sum_s[3:0];
          carry_r     <= dig_sum_s[4];
          state_r     <= ST_D2;
        end
        ST_D2: begin
          work_r[11:8] <= dig_sum_s[3:0];
          carry_r      <= dig_sum_s[4];
          state_r      <= ST_D3;
        end
        ST_D3: begin
          // Carry out of the thousands digit means the score saturates
          if (dig_sum_s[4]) begin
            work_r         <= 16'h9999;
            score_overflow <= 1'b1;
          end else begin
            work_r[15:12] <= dig_sum_s[3:0];
          end
          carry_r  <= 1'b0;
          passes_r <= passes_r - 3'd1;
          if (passes_r > 3'd1) begin
            state_r <= ST_D0;
          end else begin
            state_r <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          score_bcd        <= work_r;
          extra_ball_pulse <= (work_r[15:12] != score_bcd[15:12]);
          state_r          <= ST_IDLE;
          score_busy       <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          score_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// hit batches checked against a decimal-arithmetic reference model.
module tb_score_keeper;

`ifdef SCORE_COMBO_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sof;
  logic        clr;
  logic [5:0]  hits;
  logic [15:0] score_bcd;
  logic        score_busy;
  logic [1:0]  combo_level;
  logic        score_overflow;
  logic        extra_ball_pulse;

  int n_pass  = 0;
  int n_total = 0;
  int eb_cnt  = 0;

  // Reference model state (plain decimal arithmetic)
  int m_score  = 0;
  int m_combo  = 0;
  int m_frames = 0;
  int m_eb     = 0;
  bit m_ovf    = 1'b0;
  int pts_tab [6] = '{10, 20, 50, 5, 25, 1};

  score_keeper dut (
    .clk               (clk),
    .reset             (reset),
    .startOfFrame      (sof),
    .hit_star_pulse    (hits[0]),
    .hit_plus_pulse    (hits[1]),
    .hit_mushroom_pulse(hits[2]),
    .hit_coil_pulse    (hits[3]),
    .hit_plant_pulse   (hits[4]),
    .hit_triangle_pulse(hits[5]),
    .clear_score       (clr),
    .score_bcd         (score_bcd),
    .score_busy        (score_busy),
    .combo_level       (combo_level),
    .score_overflow    (score_overflow),
    .extra_ball_pulse  (extra_ball_pulse)
  );

  always #5 clk = ~clk;

  // Count extra-ball cycles; a pulse wider than one cycle counts more than once
  always @(negedge clk) begin
    if (extra_ball_pulse === 1'b1) eb_cnt++;
  end

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_event(input int idx);
    int mult;
    int total;
    mult  = COMBO_EN ? (1 << m_combo) : 1;
    total = m_score + pts_tab[idx] * mult;
    if (total > 9999) begin
      total = 9999;
      m_ovf = 1'b1;
    end
    if ((total / 1000) != (m_score / 1000)) m_eb++;
    m_score  = total;
    m_frames = 0;
    if (COMBO_EN && (m_combo < 2)) m_combo++;
  endtask

  task automatic model_batch(input logic [5:0] mask);
    for (int i = 0; i < 6; i++) begin
      if (mask[i]) model_event(i);
    end
  endtask

  task automatic model_clear();
    m_score  = 0;
    m_ovf    = 1'b0;
    m_combo  = 0;
    m_frames = 0;
  endtask

  task automatic pulse_hits(input logic [5:0] m);
    @(negedge clk);
    hits = m;
    @(negedge clk);
    hits = 6'd0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic wait_idle();
    int lows;
    int cyc;
    lows = 0;
    cyc  = 0;
    while ((lows < 3) && (cyc < 400)) begin
      @(negedge clk);
      cyc++;
      if (score_busy === 1'b0) lows++;
      else lows = 0;
    end
    check("idle_timeout", (lows >= 3) ? 16'd1 : 16'd0, 16'd1);
  endtask

  task automatic send_frames(input int n);
    @(negedge clk);
    sof = 1'b1;
    repeat (n) @(negedge clk);
    sof = 1'b0;
    repeat (2) @(negedge clk);
    m_frames += n;
    if (COMBO_EN && (m_frames >= 30)) m_combo = 0;
  endtask

  task automatic hit_single(input int idx);
    pulse_hits(6'd1 << idx);
    wait_idle();
    model_event(idx);
    if (COMBO_EN) send_frames(30);
  endtask

  task automatic build_to(input int target);
    int rem;
    int best;
    while (m_score < target) begin
      rem  = target - m_score;
      best = 5;
      for (int i = 0; i < 6; i++) begin
        if ((pts_tab[i] <= rem) && (pts_tab[i] > pts_tab[best])) best = i;
      end
      hit_single(best);
    end
  endtask

  initial begin
    logic [5:0] mask;
    int         eb0;
    int         f;

    reset = 1'b1;
    sof   = 1'b0;
    clr   = 1'b0;
    hits  = 6'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_score", score_bcd, 16'h0000);
    check("rst_busy", score_busy, 16'd0);
    check("rst_combo", combo_level, 16'd0);
    check("rst_ovf", score_overflow, 16'd0);
    check("rst_eb", extra_ball_pulse, 16'd0);

    // Single star: latency and busy window
    pulse_hits(6'b000001);
    check("t1_busy_pre", score_busy, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("t1_busy", score_busy, 16'd1);
    end
    check("t1_score_early", score_bcd, 16'h0000);
    @(negedge clk);
    model_event(0);
    check("t1_score", score_bcd, 16'h0010);
    check("t1_busy_post", score_busy, 16'd0);
    check("t1_combo", combo_level, 16'(m_combo));

    // Three simultaneous hits served in priority order
    do_clear();
    pulse_hits(6'b000111);
    wait_idle();
    model_batch(6'b000111);
    check("t2_score", score_bcd, COMBO_EN ? 16'h0250 : 16'h0080);
    check("t2_model", score_bcd, int2bcd(m_score));

    // Carry ripple across three digits, one extra ball
    do_clear();
    build_to(995);
    check("t3_pre", score_bcd, 16'h0995);
    eb0 = eb_cnt;
    hit_single(0);
    check("t3_score", score_bcd, 16'h1005);
    check("t3_eb", 16'(eb_cnt - eb0), 16'd1);

    // Saturation at 9999 and sticky overflow
    build_to(9990);
    check("t4_pre", score_bcd, 16'h9990);
    check("t4_ovf_pre", score_overflow, 16'd0);
    hit_single(2);
    check("t4_score", score_bcd, 16'h9999);
    check("t4_ovf", score_overflow, 16'd1);
    hit_single(5);
    check("t4_score2", score_bcd, 16'h9999);
    check("t4_ovf_sticky", score_overflow, 16'd1);
    check("t4_eb_total", 16'(eb_cnt), 16'(m_eb));

    // clear_score while the FSM is in D2
    pulse_hits(6'b000001);
    repeat (4) @(negedge clk);
    check("t6_busy_d2", score_busy, 16'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("t6_score", score_bcd, 16'h0000);
    check("t6_busy", score_busy, 16'd0);
    check("t6_ovf", score_overflow, 16'd0);
    repeat (10) @(negedge clk);
    check("t6_pending", score_busy, 16'd0);
    check("t6_score_late", score_bcd, 16'h0000);

    // clear_score overrides a pulse in the same cycle
    @(negedge clk);
    hits = 6'b000100;
    clr  = 1'b1;
    @(negedge clk);
    hits = 6'd0;
    clr  = 1'b0;
    repeat (10) @(negedge clk);
    check("clr_pulse_busy", score_busy, 16'd0);
    check("clr_pulse_score", score_bcd, 16'h0000);

    // Combo timeout after 30 idle frames
    pulse_hits(6'b000001);
    wait_idle();
    model_event(0);
    check("t5_combo_up", combo_level, 16'(m_combo));
    send_frames(29);
    check("t5_combo_hold", combo_level, 16'(m_combo));
    send_frames(1);
    check("t5_combo_drop", combo_level, 16'd0);
    pulse_hits(6'b000001);
    wait_idle();
    model_event(0);
    check("t5_score", score_bcd, 16'h0020);

    // Back-to-back pulses on a pending bit merge into one event
    do_clear();
    @(negedge clk);
    hits = 6'b000001;
    repeat (2) @(negedge clk);
    hits = 6'd0;
    wait_idle();
    model_event(0);
    check("merge_score", score_bcd, 16'h0010);

    // Pulse in the COMMIT cycle of the same bit is kept
    do_clear();
    pulse_hits(6'b000001);
    repeat (6) @(negedge clk);
    hits = 6'b000001;
    @(negedge clk);
    hits = 6'd0;
    wait_idle();
    model_event(0);
    model_event(0);
    check("setwins_score", score_bcd, COMBO_EN ? 16'h0030 : 16'h0020);

    // Asynchronous reset mid-operation
    pulse_hits(6'b000010);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_score", score_bcd, 16'h0000);
    check("arst_busy", score_busy, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (10) @(negedge clk);
    check("arst_idle", score_busy, 16'd0);

    // Randomized batches against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      mask = 6'($urandom_range(1, 63));
      pulse_hits(mask);
      wait_idle();
      model_batch(mask);
      check("rnd_score", score_bcd, int2bcd(m_score));
      check("rnd_ovf", score_overflow, 16'(m_ovf));
      check("rnd_combo", combo_level, 16'(m_combo));
      check("rnd_eb", 16'(eb_cnt), 16'(m_eb));
      f = $urandom_range(0, 40);
      if (f > 0) send_frames(f);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
